// File: rtl/lab104_irq_pending_latch.sv
// Purpose: latch rising edges of raw request lines as sticky pending bits, clear by indexed ack, count lost events.
// Latency: request rise at edge k is visible on pend_out/irq in cycle k+1; ack at edge k clears in cycle k+1.
// Backpressure: none; events arriving on an already-pending line are counted as drops, never stalled.
module lab104_irq_pending_latch #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     pend_out,
    output logic             irq,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ack_err
);

    logic [N-1:0] req_q;
    logic [N-1:0] pend_r;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] drop;
    logic         drop_any;
    logic         cnt_sat;
    logic         ack_hit;

    // One-hot clear decode; an index outside 0..N-1 simply matches no line.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = ack && (ack_idx == IDX_W'(i));
        end
    end

    // Edge detect, drop detect, and legality of the acknowledge.
    always_comb begin
        rise     = req_in & ~req_q;
        drop     = rise & pend_r & ~clr;
        drop_any = |drop;
        cnt_sat  = &drop_cnt;
        ack_hit  = |(clr & pend_r);
    end

    // Request history and pending bits; a set on the same cycle as its clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            pend_r <= '0;
        end else begin
            req_q  <= req_in;
            pend_r <= (pend_r & ~clr) | rise;
        end
    end

    // Saturating drop counter: at most one increment per cycle however many lines drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_any && !cnt_sat) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // One-cycle flag for an ack that targets a missing line or a line with nothing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err <= 1'b0;
        end else begin
            ack_err <= ack && !ack_hit;
        end
    end

    // Mask only hides bits from the consumer; latching, clearing and drop counting ignore it.
    always_comb begin
        pend_out = pend_r & ~mask;
        irq      = |pend_out;
    end

endmodule

// File: tb/tb_lab104_irq_pending_latch.sv
// Purpose: randomized and directed checking of the pending latch against a per-line event model.
// Latency: model advances on each rising edge; outputs are compared 1 time unit later.
// Backpressure: not applicable; the bench drives every input freely each cycle.
module tb_lab104_irq_pending_latch;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_in;
    logic [N-1:0]     mask;
    logic             ack;
    logic [IDX_W-1:0] ack_idx;
    logic [N-1:0]     pend_out;
    logic             irq;
    logic [CNT_W-1:0] drop_cnt;
    logic             ack_err;

    // Second instance with three lines, used for the out-of-range index case.
    logic             rst3;
    logic [2:0]       req3;
    logic [2:0]       mask3;
    logic             ack3;
    logic [1:0]       idx3;
    logic [2:0]       pend3;
    logic             irq3;
    logic [7:0]       drop3;
    logic             err3;

    int checks = 0;
    int errors = 0;

    // Reference model: per-line previous level and pending flag, plain integer drop count.
    bit m_prev [N];
    bit m_pend [N];
    int m_drop;
    bit m_err;

    always #5 clk = ~clk;

    lab104_irq_pending_latch #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .pend_out (pend_out),
        .irq      (irq),
        .drop_cnt (drop_cnt),
        .ack_err  (ack_err)
    );

    lab104_irq_pending_latch #(.N(3), .IDX_W(2), .CNT_W(8)) u_n3 (
        .clk      (clk),
        .rst      (rst3),
        .req_in   (req3),
        .mask     (mask3),
        .ack      (ack3),
        .ack_idx  (idx3),
        .pend_out (pend3),
        .irq      (irq3),
        .drop_cnt (drop3),
        .ack_err  (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the event rules for the inputs present at this clock edge.
    task automatic model_step();
        bit any_drop;
        bit rise;
        bit hit;
        int idx;
        idx = int'(ack_idx);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_drop = 0;
            m_err  = 1'b0;
        end else begin
            m_err    = ack && (idx >= N || !m_pend[idx]);
            any_drop = 1'b0;
            for (int i = 0; i < N; i++) begin
                rise = req_in[i] && !m_prev[i];
                hit  = ack && (idx == i);
                if (rise && m_pend[i] && !hit) any_drop = 1'b1;
                if (rise)     m_pend[i] = 1'b1;
                else if (hit) m_pend[i] = 1'b0;
                m_prev[i] = req_in[i];
            end
            if (any_drop && m_drop < CNT_MAX) m_drop++;
        end
    endtask

    function automatic logic [N-1:0] model_visible();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i] && !mask[i];
        return v;
    endfunction

    task automatic compare_all();
        logic [N-1:0] v;
        v = model_visible();
        check("pend_out", 32'(pend_out), 32'(v));
        check("irq",      32'(irq),      32'(|v));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("ack_err",  32'(ack_err),  32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; mask = '0; ack = 1'b0; ack_idx = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst3 = 1'b1; req3 = '0; mask3 = '0; ack3 = 1'b0; idx3 = '0;
        for (int i = 0; i < N; i++) begin m_prev[i] = 1'b0; m_pend[i] = 1'b0; end
        m_drop = 0; m_err = 1'b0;

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0; rst3 = 1'b0;
        check("rst_pend", 32'(pend_out), 32'h0);
        check("rst_irq",  32'(irq),      32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);

        // Single-cycle pulse on line 2
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        check("pulse_pend", 32'(pend_out), 32'h4);
        check("pulse_irq",  32'(irq),      32'h1);
        tick();
        check("pulse_drop", 32'(drop_cnt), 32'h0);

        // Level-held request, ack without re-latch, re-arm after a low cycle
        do_reset();
        req_in = 4'b1001;
        repeat (5) tick();
        check("hold_pend", 32'(pend_out), 32'h9);
        ack = 1'b1; ack_idx = 2'd3;
        tick();
        ack = 1'b0;
        check("ack3_pend", 32'(pend_out), 32'h1);
        tick();
        check("no_relatch", 32'(pend_out), 32'h1);
        req_in = 4'b0000;
        tick();
        req_in = 4'b1001;
        tick();
        check("rearm_pend", 32'(pend_out), 32'h9);

        // Masking is combinational and does not stop latching
        do_reset();
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        mask = 4'b0010;
        #1;
        check("mask_pend", 32'(pend_out), 32'h0);
        check("mask_irq",  32'(irq),      32'h0);
        mask = 4'b0000;
        #1;
        check("unmask_pend", 32'(pend_out), 32'h2);
        check("unmask_irq",  32'(irq),      32'h1);
        tick();

        // Drop on a pending line, no drop when acked in the same cycle, saturation
        req_in = 4'b0010;
        tick();
        check("drop_one", 32'(drop_cnt), 32'h1);
        req_in = 4'b0000;
        tick();
        req_in = 4'b0010; ack = 1'b1; ack_idx = 2'd1;
        tick();
        ack = 1'b0;
        check("set_wins",  32'(pend_out[1]), 32'h1);
        check("no_drop_ack", 32'(drop_cnt), 32'h1);
        for (int k = 0; k < 300; k++) begin
            req_in = 4'b0000;
            tick();
            req_in = 4'b0010;
            tick();
        end
        check("drop_sat", 32'(drop_cnt), 32'hFF);

        // Ack on a line with nothing pending
        do_reset();
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        ack = 1'b1; ack_idx = 2'd0;
        tick();
        ack = 1'b0;
        check("err_pulse", 32'(ack_err),  32'h1);
        check("err_keep",  32'(pend_out), 32'h4);
        tick();
        check("err_clear", 32'(ack_err),  32'h0);

        // Out-of-range index on the three-line instance
        req3 = 3'b001;
        @(posedge clk); #1;
        req3 = 3'b000;
        check("n3_pend", 32'(pend3), 32'h1);
        ack3 = 1'b1; idx3 = 2'd3;
        @(posedge clk); #1;
        ack3 = 1'b0;
        check("n3_err",     32'(err3),  32'h1);
        check("n3_keep",    32'(pend3), 32'h1);
        @(posedge clk); #1;
        check("n3_err_end", 32'(err3),  32'h0);
        model_step();

        // Reset with everything pending and an ack in the same cycle
        do_reset();
        req_in = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            req_in = 4'b0000;
            tick();
            req_in = 4'b1111;
            tick();
        end
        check("pre_rst_pend", 32'(pend_out), 32'hF);
        check("pre_rst_drop", 32'(drop_cnt), 32'h5);
        req_in = 4'b0001; rst = 1'b1; ack = 1'b1; ack_idx = 2'd2;
        tick();
        rst = 1'b0; ack = 1'b0;
        check("mid_rst_pend", 32'(pend_out), 32'h0);
        check("mid_rst_irq",  32'(irq),      32'h0);
        check("mid_rst_drop", 32'(drop_cnt), 32'h0);
        check("mid_rst_err",  32'(ack_err),  32'h0);
        tick();
        check("held_thru_rst", 32'(pend_out), 32'h1);
        tick();
        check("held_once", 32'(drop_cnt), 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            req_in  = 4'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            ack     = ($urandom_range(0, 2) == 0);
            ack_idx = 2'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; mask = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
